des_iter_controller: RTL

- Iterative single-round DES sequencer. Accepts one 64-bit post-IP block and a 64-bit key, then drives one external combinational Feistel-round datapath for 16 consecutive cycles. It runs the key schedule internally, using FIPS 46-3 PC-1, the rotation schedule and PC-2, and supports encrypt or decrypt.
- Returns the pre-FP result R16||L16 through a valid/ready handshake.
- Sits between the Triple-DES top-level stage sequencer and the shared round datapath. IP/FP permutations are outside this block.

---
 rtl/des_iter_controller.sv | 134 +++++++++++++
 1 files changed

// File: rtl/des_iter_controller.sv
// Iterative DES round sequencer: loads a post-IP block and key, steps an external
// Feistel-round datapath 16 times while running the key schedule, returns {R16,L16}.
module des_iter_controller (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [63:0] data_in,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] data_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [3:0]  round_num,
    output logic [31:0] rnd_left,
    output logic [31:0] rnd_right,
    output logic [47:0] rnd_key,
    input  logic [31:0] rnd_out_left,
    input  logic [31:0] rnd_out_right
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Table entries number bits from 1 at the MSB.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_T[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
        return r;
    endfunction

    // Schedule entries 0, 1, 8 and 15 shift by one; all others by two.
    function automatic logic shift_two(input logic [3:0] idx);
        return !(idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  cnt;
    logic        mode;
    logic [55:0] pc1_key;
    logic        two_enc, two_dec;
    logic        unused_parity;

    assign pc1_key   = pc1(key_in);
    assign two_enc   = shift_two(cnt + 4'd1);
    assign two_dec   = shift_two(~cnt);       // 16-(cnt+1) == 15-cnt
    assign rnd_left  = l_q;
    assign rnd_right = r_q;
    assign rnd_key   = pc2({c_q, d_q});
    assign round_num = cnt;
    assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            l_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            cnt       <= '0;
            mode      <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    l_q      <= data_in[63:32];
                    r_q      <= data_in[31:0];
                    mode     <= decrypt;
                    cnt      <= '0;
                    // Decrypt starts from K16, whose C/D equal the unrotated PC-1 halves.
                    c_q      <= decrypt ? pc1_key[55:28] : rotl(pc1_key[55:28], 1'b0);
                    d_q      <= decrypt ? pc1_key[27:0]  : rotl(pc1_key[27:0],  1'b0);
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    state    <= ROUND;
                end
                ROUND: begin
                    l_q <= rnd_out_left;
                    r_q <= rnd_out_right;
                    cnt <= cnt + 4'd1;
                    c_q <= mode ? rotr(c_q, two_dec) : rotl(c_q, two_enc);
                    d_q <= mode ? rotr(d_q, two_dec) : rotl(d_q, two_enc);
                    if (cnt == 4'd15) begin
                        data_out  <= {rnd_out_right, rnd_out_left};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
